quad_raster_sched: RTL
======================

Name: quad_raster_sched

Overview:
- Scanline scheduler for the quad coverage unit.
- Holds a table of up to MAX_QUADS quads (vertices plus colour) written by the game/CPU side.
- On each line_start, clears the line buffer, then presents every stored quad in index order to the coverage unit with the requested drawY.
- Writes each returned coverage mask into the line buffer in painter's order: higher index overwrites lower.

Parameters:
- WARP_WIDTH, 320, coverage mask width (pixels per scanline).
- MAX_QUADS, 8, quad table depth.
- COLOR_W, 8, colour/palette index width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- quad_wr_valid  in  1  quad write request
- quad_wr_ready  out  1  quad table accepting a write
- quad_wr_vertices  in  80  vertex v, coord c (0:x, 1:y) at bits [(v*2+c)*10 +: 10]; counter-clockwise order
- quad_wr_color  in  COLOR_W  quad colour
- quad_clear  in  1  empty the quad table
- line_start  in  1  pulse: render scanline line_y
- line_y  in  10  scanline y, sampled with line_start
- cov_vertices  out  80  registered vertices to coverage unit (same packing)
- cov_drawY  out  10  registered drawY to coverage unit
- cov_mask  in  WARP_WIDTH  coverage result (bit x = isInside[x]), combinational from cov_*
- lb_clear  out  1  clear line buffer to background
- lb_wr_en  out  1  line buffer masked write
- lb_wr_mask  out  WARP_WIDTH  pixels to write
- lb_wr_color  out  COLOR_W  colour for masked pixels
- busy  out  1  state != IDLE
- line_done  out  1  one-cycle pulse, scanline complete
- line_overrun  out  1  sticky: line_start arrived while busy
- quad_count  out  $clog2(MAX_QUADS+1)  valid table entries

Behaviour:
- Reset values:
  - All outputs are 0.
  - quad_count = 0, state = IDLE, table contents don't-care.
  - Reset mid-line abandons the line; no line_done is issued.
- States: IDLE, CLEAR, FETCH, WRITE, DONE.
- IDLE input priority:
  - Priority order is line_start > quad_clear > quad_wr.
  - quad_wr_ready = IDLE & quad_count<MAX_QUADS & !line_start & !quad_clear.
  - A write handshake (valid & ready) stores entry[quad_count] and increments quad_count.
  - quad_clear sets quad_count = 0 and drops any simultaneous write.
  - line_start latches line_y into cov_drawY and goes to CLEAR.
- CLEAR:
  - lb_clear = 1 for exactly one cycle; index = 0.
  - Go to FETCH if quad_count > 0, else DONE.
- FETCH: cov_vertices <= entry[index] vertices, lb_wr_color <= entry[index] colour. Go to WRITE.
- WRITE:
  - lb_wr_en = 1 and lb_wr_mask = cov_mask, sampled this cycle.
  - If index == quad_count-1, go to DONE; else index++ and go to FETCH.
- DONE: line_done = 1 for one cycle, then IDLE.
- Latency:
  - line_start sampled at edge t: lb_clear is high in cycle t+1.
  - Quad k is written in cycle t+3+2k.
  - line_done is high in cycle t+2+2N (N = quad_count); for N=0, at t+2.
- Busy-state inputs:
  - line_start while busy is ignored and sets line_overrun. Only reset clears line_overrun.
  - quad_wr and quad_clear are held off while busy: ready stays 0 and quad_clear is ignored. Requesters must retry in IDLE.
- Outputs outside their states: lb_wr_en and lb_clear are 0 outside WRITE and CLEAR respectively. lb_wr_mask holds its value otherwise.
- Full table: quad_count == MAX_QUADS forces ready = 0 and never wraps.

Optional Feature:
- Macro QUAD_YBOUNDS_EN.
- Defined:
  - On write, store ymin/ymax = min/max of the four vertex y values.
  - In FETCH, if cov_drawY < ymin or cov_drawY > ymax, skip the quad: no WRITE cycle, index++ or go to DONE. A skipped quad costs 1 cycle.
  - The coverage result of a skipped quad is never written.
- Undefined:
  - No bound storage; every quad costs 2 cycles.
  - Latency formula above is exact.

Test Plan:
1. Reset, then line_start with line_y=5 and empty table -> lb_clear high in t+1, line_done in t+2, no lb_wr_en.
2. Write quad (0,0),(0,100),(100,100),(100,0) colour 3, line_start y=50 -> one lb_wr_en with colour 3; mask equals the stub coverage model for drawY=50; line_done at t+4.
3. Fill 8 quads -> quad_wr_ready=0 at count 8, 9th write not accepted; line_start -> lb_wr_en colours in index order 0..7; line_done at t+18.
4. line_start pulsed mid-line -> line_overrun=1 and stays 1, current line finishes normally; quad_clear during busy ignored (count unchanged).
5. Same cycle in IDLE: quad_clear=1, quad_wr_valid=1 -> count=0, ready=0; then line_start with quad_wr_valid -> line starts, write not accepted.
6. QUAD_YBOUNDS_EN: quad spanning y 10..20, line_y=30 -> no lb_wr_en, line_done at t+3; line_y=15 -> written. Also assert rst_n low mid-line -> all outputs 0, no line_done.

Source files
------------

// File: rtl/quad_raster_sched.sv
// quad_raster_sched
//   Scanline scheduler for the quad coverage unit. Holds up to MAX_QUADS quads
//   (four vertices plus colour). On line_start it clears the line buffer, then
//   presents each stored quad in index order to the coverage unit and writes
//   the returned mask into the line buffer. Higher indices land later, so they
//   overwrite lower ones (painter's order).
//
//   Optional build macro QUAD_YBOUNDS_EN: store per-quad y bounds on write.
//   Quads whose bounds miss the current scanline are skipped in one cycle,
//   with no WRITE cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   quad_wr_*           quad table write handshake (vertices, colour)
//   quad_clear          empty the quad table (IDLE only)
//   line_start, line_y  render request for one scanline
//   cov_vertices/drawY  registered request to the coverage unit
//   cov_mask            combinational coverage result for cov_*
//   lb_clear            one-cycle line buffer clear
//   lb_wr_en/mask/color masked line buffer write
//   busy, line_done     status; line_done pulses once per finished line
//   line_overrun        sticky flag: line_start arrived while busy
//   quad_count          number of valid table entries
module quad_raster_sched #(
    parameter int WARP_WIDTH = 320,
    parameter int MAX_QUADS  = 8,
    parameter int COLOR_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           quad_wr_valid,
    output logic                           quad_wr_ready,
    input  logic [79:0]                    quad_wr_vertices,
    input  logic [COLOR_W-1:0]             quad_wr_color,
    input  logic                           quad_clear,
    input  logic                           line_start,
    input  logic [9:0]                     line_y,
    output logic [79:0]                    cov_vertices,
    output logic [9:0]                     cov_drawY,
    input  logic [WARP_WIDTH-1:0]          cov_mask,
    output logic                           lb_clear,
    output logic                           lb_wr_en,
    output logic [WARP_WIDTH-1:0]          lb_wr_mask,
    output logic [COLOR_W-1:0]             lb_wr_color,
    output logic                           busy,
    output logic                           line_done,
    output logic                           line_overrun,
    output logic [$clog2(MAX_QUADS+1)-1:0] quad_count
);
    localparam int CW = $clog2(MAX_QUADS+1);
    localparam int IW = (MAX_QUADS > 1) ? $clog2(MAX_QUADS) : 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_QUADS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef struct packed {
        logic [79:0]        vert;
        logic [COLOR_W-1:0] color;
`ifdef QUAD_YBOUNDS_EN
        logic [9:0]         ymin;
        logic [9:0]         ymax;
`endif
    } entry_t;

    logic [2:0]            state;
    logic [IW-1:0]         index;
    logic [WARP_WIDTH-1:0] mask_q;
    logic                  up;
    entry_t                tbl [MAX_QUADS];
    entry_t                wr_entry;
    entry_t                cur;
    logic                  wr_fire;
    logic                  last;
    logic                  skip;

`ifdef QUAD_YBOUNDS_EN
    function automatic logic [9:0] vy(input logic [79:0] v, input int i);
        return v[(i*2+1)*10 +: 10];
    endfunction
`endif

    always_comb begin
        wr_entry       = '0;
        wr_entry.vert  = quad_wr_vertices;
        wr_entry.color = quad_wr_color;
`ifdef QUAD_YBOUNDS_EN
        wr_entry.ymin  = vy(quad_wr_vertices, 0);
        wr_entry.ymax  = vy(quad_wr_vertices, 0);
        for (int i = 1; i < 4; i++) begin
            if (vy(quad_wr_vertices, i) < wr_entry.ymin) wr_entry.ymin = vy(quad_wr_vertices, i);
            if (vy(quad_wr_vertices, i) > wr_entry.ymax) wr_entry.ymax = vy(quad_wr_vertices, i);
        end
`endif
    end

    assign cur  = tbl[index];
    assign last = (CW'(index) == quad_count - CW'(1));

`ifdef QUAD_YBOUNDS_EN
    assign skip = (cov_drawY < cur.ymin) || (cov_drawY > cur.ymax);
`else
    assign skip = 1'b0;
`endif

    // 'up' keeps ready low while reset is asserted so every output reads 0.
    assign quad_wr_ready = up && (state == S_IDLE) && (quad_count < FULL)
                           && !line_start && !quad_clear;
    assign wr_fire       = quad_wr_valid && quad_wr_ready;

    assign lb_clear   = (state == S_CLEAR);
    assign lb_wr_en   = (state == S_WRITE);
    assign busy       = (state != S_IDLE);
    assign line_done  = (state == S_DONE);
    // Mask passes straight through in WRITE and holds the last written mask otherwise.
    assign lb_wr_mask = lb_wr_en ? cov_mask : mask_q;

    // Table storage carries no reset; contents are only meaningful below quad_count.
    always_ff @(posedge clk) begin
        if (wr_fire) tbl[quad_count[IW-1:0]] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            index        <= '0;
            mask_q       <= '0;
            up           <= 1'b0;
            cov_vertices <= '0;
            cov_drawY    <= '0;
            lb_wr_color  <= '0;
            line_overrun <= 1'b0;
            quad_count   <= '0;
        end else begin
            up <= 1'b1;
            if (line_start && state != S_IDLE) line_overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (line_start) begin
                        cov_drawY <= line_y;
                        state     <= S_CLEAR;
                    end else if (quad_clear) begin
                        quad_count <= '0;
                    end else if (wr_fire) begin
                        quad_count <= quad_count + CW'(1);
                    end
                end
                S_CLEAR: begin
                    index <= '0;
                    state <= (quad_count != '0) ? S_FETCH : S_DONE;
                end
                S_FETCH: begin
                    if (skip) begin
                        // Out-of-range quad: move on without touching the coverage unit.
                        if (last) state <= S_DONE;
                        else      index <= index + IW'(1);
                    end else begin
                        cov_vertices <= cur.vert;
                        lb_wr_color  <= cur.color;
                        state        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    mask_q <= cov_mask;
                    if (last) begin
                        state <= S_DONE;
                    end else begin
                        index <= index + IW'(1);
                        state <= S_FETCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
